fifo_irq_ctrl: RTL and testbench
================================

// Module: fifo_irq_ctrl
// PURPOSE
//  Controller sequencing the OpenDVS event FIFO (sync_fifo_top) between pixel-event producer and SPI host.
//  Gates event writes into the FIFO and drives FIFO soft-clear from the register-file request.
//  Raises a hysteretic IRQ from fill level, with an age timeout. Keeps a saturating count of dropped events.
//  Sits beside spi_fifo_regfile: inputs come from regfile config regs and FIFO status; outputs feed FIFO and pad.
// PARAMETERS
//  DEPTH        16  FIFO depth in entries; AW=$clog2(DEPTH) is the width of numel/thresholds
//  FLUSH_CYC     4  cycles fifo_rst_n is held low during a soft clear (>=1)
//  TO_W         16  width of timeout counter/config
// PORTS
//  clk            in   1       system clock (all logic on posedge)
//  rst_n          in   1       reset: synchronous, active-low
//  ctrl_en        in   1       block enable (regfile bit); 0 = drop all events, IRQ low
//  soft_clr       in   1       1-cycle pulse request to clear FIFO (fifo_rst_n_reg edge)
//  evt_valid      in   1       producer has an event this cycle (1 event/cycle max)
//  numel_fifo     in   AW      FIFO occupancy; DEPTH entries reported via full_fifo
//  full_fifo      in   1       FIFO full
//  empty_fifo     in   1       FIFO empty
//  irq_assert_th  in   AW      assert IRQ when occupancy >= this
//  irq_deassert_th in  AW      deassert IRQ when occupancy <= this
//  timeout_cyc    in   TO_W    age timeout; 0 disables timeout IRQ
//  wr_en_fifo     out  1       gated write strobe to FIFO
//  fifo_rst_n     out  1       active-low synchronous clear to FIFO
//  irq            out  1       interrupt to host (level)
//  drop_cnt       out  16      saturating dropped-event count
//  state          out  2       FSM state: 0 IDLE, 1 RUN, 2 FLUSH
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, wr_en_fifo=0, fifo_rst_n=0, irq=0, drop_cnt=0, timer=0.
//  Occupancy occ = full_fifo ? DEPTH : numel_fifo (AW+1 bits); all compares unsigned on AW+1 bits.
//  FSM (registered, one transition per cycle):
//   IDLE : ctrl_en=1 -> FLUSH (FIFO always cleared on entry). Else stay.
//   RUN  : soft_clr=1 or ctrl_en=0 -> FLUSH / IDLE respectively (soft_clr has priority).
//   FLUSH: fifo_rst_n=0 for FLUSH_CYC cycles (counter), then -> RUN, or -> IDLE if ctrl_en=0.
//   soft_clr during FLUSH restarts the flush counter; soft_clr in IDLE is ignored.
//  fifo_rst_n: 0 in IDLE and FLUSH, 1 in RUN; registered, changes the cycle after the state change.
//  wr_en_fifo = evt_valid & (state==RUN) & ~full_fifo; combinational, same cycle as evt_valid.
//  Drop: evt_valid & ~wr_en_fifo in RUN or FLUSH -> drop_cnt+1 next cycle; holds at 16'hFFFF.
//   Events in IDLE are not counted. drop_cnt cleared only by rst_n or soft_clr (same cycle as pulse).
//  IRQ (registered, RUN only; forced 0 in IDLE/FLUSH):
//   set when occ >= irq_assert_th, or timer expiry; clear when occ <= irq_deassert_th and no timer expiry.
//   If assert_th <= deassert_th, set has priority (IRQ follows occ >= assert_th).
//   assert_th=0 is treated as 1 (empty FIFO never raises occupancy IRQ).
//  Timer: counts cycles while RUN & ~empty_fifo & ~irq; reset to 0 when empty, on IRQ, on leaving RUN.
//   On reaching timeout_cyc (!=0), irq=1 next cycle; timer holds until reset.
//  Simultaneous FIFO read and write do not affect the controller; it only samples occ.
// TESTING
//  1 Reset, ctrl_en=1 at cycle 0, FLUSH_CYC=4 -> state IDLE->FLUSH (4 cyc, fifo_rst_n=0)->RUN; fifo_rst_n=1.
//  2 assert_th=8, deassert_th=2; write 8 events -> irq=1 when occ=8; drain to 3 -> still 1; drain to 2 -> irq=0.
//  3 Fill to DEPTH=16 (full_fifo=1), 5 more evt_valid -> wr_en_fifo=0, drop_cnt=5; preload 16'hFFFE +3 -> FFFF.
//  4 timeout_cyc=100, assert_th=8, write 1 event -> irq=1 101 cycles later; read it (empty) -> irq=0, timer=0.
//  5 soft_clr mid-RUN with occ=6, irq=1 -> FLUSH, irq=0, drop_cnt=0, evt_valid in FLUSH counted; RUN after 4 cyc.
//  6 rst_n=0 mid-FLUSH and with drop_cnt=9 -> all outputs to reset values next posedge; ctrl_en=0 -> stays IDLE.

Source files
------------

// File: rtl/fifo_irq_ctrl.sv
// fifo_irq_ctrl: gates event writes into the event FIFO, sequences soft clears, raises a hysteretic/timeout IRQ and counts drops
module fifo_irq_ctrl #(
  parameter int DEPTH     = 16,
  parameter int FLUSH_CYC = 4,
  parameter int TO_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ctrl_en,
  input  logic                       soft_clr,
  input  logic                       evt_valid,
  input  logic [$clog2(DEPTH)-1:0]   numel_fifo,
  input  logic                       full_fifo,
  input  logic                       empty_fifo,
  input  logic [$clog2(DEPTH)-1:0]   irq_assert_th,
  input  logic [$clog2(DEPTH)-1:0]   irq_deassert_th,
  input  logic [TO_W-1:0]            timeout_cyc,
  output logic                       wr_en_fifo,
  output logic                       fifo_rst_n,
  output logic                       irq,
  output logic [15:0]                drop_cnt,
  output logic [1:0]                 state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FLUSH_CYC + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
  state_t st, st_n;
  logic [CW-1:0] fcnt;
  logic [TO_W-1:0] timer;
  logic [AW:0] occ, ath;
  logic tmo, irq_n, drop_inc;
  assign state      = st;
  assign occ        = full_fifo ? (AW+1)'(DEPTH) : {1'b0, numel_fifo};
  assign ath        = irq_assert_th == '0 ? (AW+1)'(1) : {1'b0, irq_assert_th};
  assign wr_en_fifo = evt_valid & (st == RUN) & ~full_fifo;
  assign drop_inc   = evt_valid & ~wr_en_fifo & (st == RUN | st == FLUSH);
  // expiry is ignored once the FIFO is empty so a drained FIFO drops the IRQ immediately
  assign tmo        = (timeout_cyc != '0) && (timer == timeout_cyc) && !empty_fifo;
  always_comb begin
    st_n  = st == IDLE ? (ctrl_en ? FLUSH : IDLE)
          : st == RUN  ? (soft_clr ? FLUSH : ctrl_en ? RUN : IDLE)
          : (!soft_clr && fcnt == CW'(FLUSH_CYC - 1)) ? (ctrl_en ? RUN : IDLE) : FLUSH;
    irq_n = (st_n == RUN) && (occ >= ath || tmo || (irq && !(occ <= {1'b0, irq_deassert_th})));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= IDLE;
      fcnt       <= '0;
      fifo_rst_n <= 1'b0;
      irq        <= 1'b0;
      drop_cnt   <= '0;
      timer      <= '0;
    end else begin
      st         <= st_n;
      fcnt       <= (st == FLUSH && st_n == FLUSH && !soft_clr) ? fcnt + 1'b1 : '0;
      fifo_rst_n <= st == RUN;
      irq        <= irq_n;
      drop_cnt   <= soft_clr ? '0 : (drop_inc && drop_cnt != 16'hFFFF) ? drop_cnt + 1'b1 : drop_cnt;
      // an expired timer holds while its IRQ is pending; an occupancy IRQ restarts it
      timer      <= (st_n != RUN || empty_fifo || (irq && !tmo)) ? '0
                  : (!irq && timer != timeout_cyc) ? timer + 1'b1 : timer;
    end
  end
endmodule

// File: tb/tb_fifo_irq_ctrl.sv
// tb_fifo_irq_ctrl: directed vectors for fifo_irq_ctrl with FIFO status driven by hand
module tb_fifo_irq_ctrl;
  logic clk = 0, rst_n, ctrl_en, soft_clr, evt_valid, full_fifo, empty_fifo;
  logic [3:0] numel_fifo, irq_assert_th, irq_deassert_th;
  logic [15:0] timeout_cyc, drop_cnt;
  logic wr_en_fifo, fifo_rst_n, irq;
  logic [1:0] state;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  fifo_irq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .soft_clr(soft_clr), .evt_valid(evt_valid),
    .numel_fifo(numel_fifo), .full_fifo(full_fifo), .empty_fifo(empty_fifo),
    .irq_assert_th(irq_assert_th), .irq_deassert_th(irq_deassert_th), .timeout_cyc(timeout_cyc),
    .wr_en_fifo(wr_en_fifo), .fifo_rst_n(fifo_rst_n), .irq(irq), .drop_cnt(drop_cnt), .state(state)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 0; ctrl_en = 0; soft_clr = 0; evt_valid = 0; full_fifo = 0; empty_fifo = 1;
    numel_fifo = 0; irq_assert_th = 8; irq_deassert_th = 2; timeout_cyc = 0;
    step(2);
    check("rst_state", state, 0);
    check("rst_fifo_rst_n", fifo_rst_n, 0);
    check("rst_irq", irq, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_wr_en", wr_en_fifo, 0);
    rst_n = 1; ctrl_en = 1;
    step(1);
    check("t1_flush", state, 2);
    check("t1_flush_rst", fifo_rst_n, 0);
    step(3);
    check("t1_flush_last", state, 2);
    step(1);
    check("t1_run", state, 1);
    check("t1_rst_lag", fifo_rst_n, 0);
    step(1);
    check("t1_rst_rel", fifo_rst_n, 1);
    evt_valid = 1; empty_fifo = 0;
    #1 check("t2_wr_en", wr_en_fifo, 1);
    for (int i = 1; i <= 8; i++) begin
      numel_fifo = 4'(i);
      step(1);
      if (i == 7) check("t2_irq_occ7", irq, 0);
    end
    check("t2_irq_occ8", irq, 1);
    evt_valid = 0; numel_fifo = 3;
    step(2);
    check("t2_irq_occ3", irq, 1);
    numel_fifo = 2;
    step(1);
    check("t2_irq_occ2", irq, 0);
    check("t2_no_drop", drop_cnt, 0);
    numel_fifo = 0; full_fifo = 1; evt_valid = 1;
    #1 check("t3_wr_en_full", wr_en_fifo, 0);
    step(5);
    evt_valid = 0;
    step(1);
    check("t3_drop5", drop_cnt, 5);
    check("t3_irq_full", irq, 1);
    evt_valid = 1;
    step(65529);
    check("t3_drop_fffe", drop_cnt, 16'hFFFE);
    step(3);
    check("t3_drop_sat", drop_cnt, 16'hFFFF);
    evt_valid = 0; full_fifo = 0; numel_fifo = 0; empty_fifo = 1;
    step(1);
    check("t4_irq_empty", irq, 0);
    timeout_cyc = 100; evt_valid = 1;
    step(1);
    evt_valid = 0; numel_fifo = 1; empty_fifo = 0;
    step(100);
    check("t4_irq_before", irq, 0);
    check("t4_timer100", dut.timer, 100);
    step(1);
    check("t4_irq_timeout", irq, 1);
    step(3);
    check("t4_irq_hold", irq, 1);
    numel_fifo = 0; empty_fifo = 1;
    step(1);
    check("t4_irq_drained", irq, 0);
    check("t4_timer_clr", dut.timer, 0);
    timeout_cyc = 0; irq_assert_th = 4; numel_fifo = 6; empty_fifo = 0;
    step(1);
    check("t5_irq_pre", irq, 1);
    soft_clr = 1;
    step(1);
    soft_clr = 0; numel_fifo = 0; empty_fifo = 1;
    check("t5_flush", state, 2);
    check("t5_irq_off", irq, 0);
    check("t5_drop_clr", drop_cnt, 0);
    evt_valid = 1;
    #1 check("t5_wr_en_flush", wr_en_fifo, 0);
    step(2);
    evt_valid = 0;
    check("t5_drop_flush", drop_cnt, 2);
    check("t5_fifo_rst", fifo_rst_n, 0);
    step(1);
    check("t5_still_flush", state, 2);
    step(1);
    check("t5_run", state, 1);
    soft_clr = 1;
    step(1);
    soft_clr = 0; full_fifo = 1; evt_valid = 1;
    step(9);
    evt_valid = 0; ctrl_en = 0;
    check("t6_drop9", drop_cnt, 9);
    step(1);
    check("t6_idle", state, 0);
    ctrl_en = 1;
    step(2);
    check("t6_mid_flush", state, 2);
    check("t6_drop_kept", drop_cnt, 9);
    rst_n = 0; ctrl_en = 0; evt_valid = 1;
    step(1);
    check("t6_rst_state", state, 0);
    check("t6_rst_fifo_rst", fifo_rst_n, 0);
    check("t6_rst_irq", irq, 0);
    check("t6_rst_drop", drop_cnt, 0);
    check("t6_rst_wr_en", wr_en_fifo, 0);
    rst_n = 1;
    step(3);
    check("t6_stay_idle", state, 0);
    check("t6_idle_no_drop", drop_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
